// File: rtl/ev21_pkg.sv
// Shared opcode match constants, FSM state encoding and default widths for the EV21 sequencer.
package ev21_pkg;

  localparam int PC_W_DEF        = 11;
  localparam int INSTR_W_DEF     = 22;
  localparam int STACK_DEPTH_DEF = 8;
  localparam int PMEM_LAT_DEF    = 1;
  localparam int DMEM_WAIT_DEF   = 2;

  // Control-flow opcodes are matched on instruction bits [21:11] (BSR on [21:10]).
  localparam logic [10:0] OP_JUMP    = 11'b10000000000;
  localparam logic [10:0] OP_JZE     = 11'b10100000000;
  localparam logic [10:0] OP_JP0     = 11'b11000000000;
  localparam logic [10:0] OP_JCY     = 11'b11100000000;
  localparam logic [10:0] OP_MOM_PFX = 11'b01000000000;
  localparam logic [11:0] OP_BSR     = 12'b011100000000;

  localparam logic [21:0] INSTR_RET  = 22'b0000011000000000000000;
  localparam logic [21:0] INSTR_NOP  = 22'b0111111111111111111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_MEMW  = 2'd3
  } state_t;

endpackage

// File: rtl/ev21_ret_stack.sv
// Return-address LIFO for BSR/RET; pushes when full and pops when empty are ignored here.
module ev21_ret_stack #(
  parameter int PC_W  = 11,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  logic [SP_W-1:0] sp;
  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  // sp counts occupied entries; the extra bit distinguishes full from empty.
  assign wr_idx = sp[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      sp          <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/ev21_sequencer.sv
// EV21 program sequencer: PC, instruction fetch, control flow and MOM wait stretching.
// Optional single-step input STEP is enabled by defining EV21_SINGLE_STEP_EN.
module ev21_sequencer
  import ev21_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int PMEM_LAT    = PMEM_LAT_DEF,
  parameter int DMEM_WAIT   = DMEM_WAIT_DEF
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic               RUN,
`ifdef EV21_SINGLE_STEP_EN
  input  logic               STEP,
`endif
  output logic [PC_W-1:0]    PMEM_ADDR,
  input  logic [INSTR_W-1:0] PMEM_DATA,
  input  logic               FLAG_Z,
  input  logic               FLAG_P0,
  input  logic               FLAG_CY,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               HOLD,
  output logic [PC_W-1:0]    PC,
  output logic               BUSY,
  output logic               STK_ERR
);

  localparam int MAX_CNT = (PMEM_LAT > DMEM_WAIT) ? PMEM_LAT : DMEM_WAIT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_t             state_q, state_d, state_after;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc, br_tgt, bsr_tgt, stk_top;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stk_err_q, stk_err_d;
  logic               push, pop, full, empty, go;
  logic [10:0]        op11;
  logic [11:0]        op12;

`ifdef EV21_SINGLE_STEP_EN
  assign go          = RUN | STEP;
  assign state_after = ST_IDLE;
`else
  assign go          = RUN;
  assign state_after = RUN ? ST_FETCH : ST_IDLE;
`endif

  assign pc_inc  = pc_q + PC_W'(1);
  assign br_tgt  = instr_q[PC_W-1:0];
  assign bsr_tgt = {1'b0, instr_q[PC_W-2:0]};
  assign op11    = instr_q[INSTR_W-1 -: 11];
  assign op12    = instr_q[INSTR_W-1 -: 12];

  ev21_ret_stack #(
    .PC_W  (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (RST_N),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= INSTR_NOP;
      cnt_q     <= '0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      stk_err_q <= stk_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    stk_err_d = stk_err_q;
    push      = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        if (cnt_q == CNT_W'(PMEM_LAT - 1)) begin
          instr_d = PMEM_DATA;
          state_d = ST_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        pc_d  = pc_inc;
        cnt_d = '0;
        if (op11 == OP_JUMP) begin
          pc_d = br_tgt;
        end else if (op11 == OP_JZE) begin
          if (FLAG_Z) pc_d = br_tgt;
        end else if (op11 == OP_JP0) begin
          if (FLAG_P0) pc_d = br_tgt;
        end else if (op11 == OP_JCY) begin
          if (FLAG_CY) pc_d = br_tgt;
        end else if (op12 == OP_BSR) begin
          // Overflow still branches; only the return address is lost.
          pc_d = bsr_tgt;
          if (full) stk_err_d = 1'b1;
          else      push      = 1'b1;
        end else if (instr_q == INSTR_RET) begin
          if (empty) begin
            stk_err_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end
        if ((op11 == OP_MOM_PFX) && (DMEM_WAIT > 0)) state_d = ST_MEMW;
        else                                         state_d = state_after;
      end
      ST_MEMW: begin
        if (cnt_q == CNT_W'(DMEM_WAIT - 1)) state_d = state_after;
        else                                cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The decoder only ever sees a real instruction during EXEC and the MEMW stretch.
  assign INSTRUCTION = ((state_q == ST_EXEC) || (state_q == ST_MEMW)) ? instr_q : INSTR_NOP;
  assign HOLD        = (state_q == ST_MEMW);
  assign BUSY        = (state_q != ST_IDLE);
  assign PMEM_ADDR   = pc_q;
  assign PC          = pc_q;
  assign STK_ERR     = stk_err_q;

endmodule

// File: tb/tb_ev21_sequencer.sv
// Directed bench for ev21_sequencer with an execution-order scoreboard over a behavioural program memory.
module tb_ev21_sequencer;

  localparam logic [21:0] NOP  = 22'h1FFFFF;
  localparam logic [21:0] FILL = 22'h000001;
  localparam logic [21:0] RET  = 22'h018000;
  localparam logic [21:0] MOM  = 22'h100000;
`ifdef EV21_SINGLE_STEP_EN
  localparam int STRIDE = 3;
`else
  localparam int STRIDE = 2;
`endif

  typedef struct {
    logic [10:0] addr;
    logic [21:0] instr;
    int          holds;
  } exp_t;

  logic        clk = 1'b0;
  logic        RST_N, RUN, FLAG_Z, FLAG_P0, FLAG_CY;
`ifdef EV21_SINGLE_STEP_EN
  logic        STEP;
`endif
  logic [10:0] PMEM_ADDR, PC;
  logic [21:0] PMEM_DATA, INSTRUCTION;
  logic        HOLD, BUSY, STK_ERR;
  logic [21:0] pmem [2048];

  exp_t        q[$];
  exp_t        cur;
  bit          have_cur;
  int          hold_cnt;
  logic [21:0] prev_instr;
  int          checks, passed, fails;

  always #5 clk = ~clk;
  assign PMEM_DATA = pmem[PMEM_ADDR];

  ev21_sequencer dut (
    .clk         (clk),
    .RST_N       (RST_N),
    .RUN         (RUN),
`ifdef EV21_SINGLE_STEP_EN
    .STEP        (STEP),
`endif
    .PMEM_ADDR   (PMEM_ADDR),
    .PMEM_DATA   (PMEM_DATA),
    .FLAG_Z      (FLAG_Z),
    .FLAG_P0     (FLAG_P0),
    .FLAG_CY     (FLAG_CY),
    .INSTRUCTION (INSTRUCTION),
    .HOLD        (HOLD),
    .PC          (PC),
    .BUSY        (BUSY),
    .STK_ERR     (STK_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input logic [21:0] v);
    for (int i = 0; i < 2048; i++) pmem[i] = v;
  endtask

  task automatic push_exp(input logic [10:0] a, input logic [21:0] ins, input int h);
    exp_t e;
    e.addr  = a;
    e.instr = ins;
    e.holds = h;
    q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    PC,          0);
    chk({tag, "_addr"},  PMEM_ADDR,   0);
    chk({tag, "_hold"},  HOLD,        0);
    chk({tag, "_busy"},  BUSY,        0);
    chk({tag, "_err"},   STK_ERR,     0);
    chk({tag, "_instr"}, INSTRUCTION, NOP);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RUN     = 1'b0;
`ifdef EV21_SINGLE_STEP_EN
    STEP    = 1'b0;
`endif
    FLAG_Z  = 1'b0;
    FLAG_P0 = 1'b0;
    FLAG_CY = 1'b0;
    RST_N   = 1'b0;
    #1;
    chk_reset_vals("reset");
    q.delete();
    have_cur   = 1'b0;
    hold_cnt   = 0;
    prev_instr = NOP;
    @(negedge clk);
    RST_N = 1'b1;
  endtask

  // One cycle of monitoring: an EXEC is recognised where INSTRUCTION leaves NOP.
  task automatic tick();
    @(negedge clk);
    if (HOLD === 1'b1) begin
      hold_cnt++;
      chk("hold_instr", INSTRUCTION, cur.instr);
    end
    if (INSTRUCTION !== NOP && prev_instr === NOP) begin
      if (have_cur) chk("hold_len", hold_cnt, cur.holds);
      chk("exec_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        cur      = q.pop_front();
        have_cur = 1'b1;
        hold_cnt = 0;
        chk("exec_addr",  PMEM_ADDR,   cur.addr);
        chk("exec_pc",    PC,          cur.addr);
        chk("exec_instr", INSTRUCTION, cur.instr);
      end
    end
    prev_instr = INSTRUCTION;
  endtask

  task automatic run_until(input int left, input int budget);
    int n = 0;
    while (q.size() > left && n < budget) begin
      tick();
      n++;
    end
    chk("sb_drain", q.size(), left);
  endtask

  task automatic end_phase();
    int n = 0;
    RUN = 1'b0;
    while (BUSY !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("idle", BUSY, 0);
    if (have_cur) chk("hold_len_last", hold_cnt, cur.holds);
    have_cur = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    fails  = 0;
    RST_N  = 1'b0;
    RUN    = 1'b0;
`ifdef EV21_SINGLE_STEP_EN
    STEP   = 1'b0;
`endif
    FLAG_Z = 1'b0;
    FLAG_P0 = 1'b0;
    FLAG_CY = 1'b0;
    prev_instr = NOP;

    // Free-running NOPs: address advances once per instruction, never held.
    fill_mem(NOP);
    do_reset();
    RUN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("nop_addr", PMEM_ADDR, (k + STRIDE - 3) / STRIDE);
      chk("nop_hold", HOLD, 0);
      chk("nop_busy", BUSY, 1);
    end
    end_phase();

    // JUMP, MOM stretch, JZE not taken, BSR/RET, JP0 taken, JCY not taken.
    do_reset();
    fill_mem(FILL);
    pmem[11'h003] = 22'h200155;
    pmem[11'h155] = 22'h200004;
    pmem[11'h004] = MOM;
    pmem[11'h005] = 22'h280020;
    pmem[11'h007] = 22'h1C0010;
    pmem[11'h010] = RET;
    pmem[11'h008] = 22'h300030;
    pmem[11'h030] = 22'h380040;
    push_exp(11'h000, FILL, 0);
    push_exp(11'h001, FILL, 0);
    push_exp(11'h002, FILL, 0);
    push_exp(11'h003, 22'h200155, 0);
    push_exp(11'h155, 22'h200004, 0);
    push_exp(11'h004, MOM, 2);
    push_exp(11'h005, 22'h280020, 0);
    push_exp(11'h006, FILL, 0);
    push_exp(11'h007, 22'h1C0010, 0);
    push_exp(11'h010, RET, 0);
    push_exp(11'h008, 22'h300030, 0);
    push_exp(11'h030, 22'h380040, 0);
    push_exp(11'h031, FILL, 0);
    FLAG_P0 = 1'b1;
    RUN = 1'b1;
    run_until(0, 200);
    end_phase();
    chk("b_final_pc", PC, 11'h032);
    chk("b_err", STK_ERR, 0);

    // JZE/JCY taken, then RET on an empty stack at 0x7FF wraps to 0.
    do_reset();
    fill_mem(FILL);
    pmem[11'h000] = 22'h280020;
    pmem[11'h020] = 22'h3807FF;
    pmem[11'h7FF] = RET;
    push_exp(11'h000, 22'h280020, 0);
    push_exp(11'h020, 22'h3807FF, 0);
    push_exp(11'h7FF, RET, 0);
    push_exp(11'h000, 22'h280020, 0);
    FLAG_Z  = 1'b1;
    FLAG_CY = 1'b1;
    RUN = 1'b1;
    run_until(1, 100);
    chk("c_err_before", STK_ERR, 0);
    run_until(0, 50);
    end_phase();
    chk("c_final_pc", PC, 11'h020);
    chk("c_err_after", STK_ERR, 1);

    // Nine nested BSRs overflow an 8-deep stack; later RETs unwind LIFO order.
    do_reset();
    fill_mem(FILL);
    for (int i = 0; i < 9; i++) begin
      pmem[i] = 22'h1C0000 | 22'(i + 1);
      push_exp(11'(i), 22'h1C0000 | 22'(i + 1), 0);
    end
    pmem[11'h009] = RET;
    push_exp(11'h009, RET, 0);
    push_exp(11'h008, 22'h1C0009, 0);
    push_exp(11'h009, RET, 0);
    RUN = 1'b1;
    run_until(3, 200);
    chk("d_err_before", STK_ERR, 0);
    run_until(2, 50);
    chk("d_err_overflow", STK_ERR, 1);
    run_until(0, 50);
    end_phase();
    chk("d_final_pc", PC, 11'h009);
    chk("d_err_sticky", STK_ERR, 1);

    // Reset asserted during the MOM wait clears everything at once.
    do_reset();
    fill_mem(FILL);
    pmem[11'h000] = MOM;
    push_exp(11'h000, MOM, 2);
    RUN = 1'b1;
    run_until(0, 50);
    tick();
    chk("e_memw_hold", HOLD, 1);
    chk("e_memw_pc", PC, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_vals("e_async");
    RUN      = 1'b0;
    have_cur = 1'b0;
    @(negedge clk);
    RST_N = 1'b1;
    prev_instr = NOP;
    tick();
    chk("e_stay_idle", BUSY, 0);

`ifdef EV21_SINGLE_STEP_EN
    // One STEP pulse with RUN low executes exactly one instruction.
    do_reset();
    fill_mem(FILL);
    push_exp(11'h000, FILL, 0);
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("ss_drained", q.size(), 0);
    chk("ss_busy", BUSY, 0);
    chk("ss_pc", PC, 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
